// File: rtl/mai_forward_addr_gen.sv
// Sprite ROM address generator for the Mai forward-walk renderer.
// Registers the in-box flag and the ROM address, and runs the frame-paced walk animation FSM.
module mai_forward_addr_gen #(
    parameter int unsigned SPR_W           = 64,
    parameter int unsigned SPR_H           = 96,
    parameter int unsigned NUM_FRAMES      = 5,
    parameter int unsigned TICKS_PER_FRAME = 6
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic [9:0]  drawX,
    input  logic [9:0]  drawY,
    input  logic        frame_start,
    input  logic        walk_en,
    input  logic        mirror,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    output logic [14:0] rom_address,
    output logic        sprite_on,
    output logic [2:0]  frame_idx
);

    localparam int unsigned XSH      = $clog2(SPR_W);
    localparam int unsigned FRAME_SZ = SPR_W * SPR_H;
    localparam int unsigned CW       = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

    localparam logic [CW-1:0] TICK_LAST  = CW'(TICKS_PER_FRAME - 1);
    localparam logic [2:0]    FRAME_LAST = 3'(NUM_FRAMES - 1);
    localparam logic [10:0]   W_M1       = 11'(SPR_W - 1);
    localparam logic [10:0]   H_M1       = 11'(SPR_H - 1);

    typedef enum logic {S_IDLE, S_WALK} state_t;

    state_t        r_state;
    logic [CW-1:0] r_tick;
    logic [2:0]    r_frame;
    logic [14:0]   r_addr;
    logic          r_on;

    logic [10:0] w_x;
    logic [10:0] w_y;
    logic [10:0] w_px;
    logic [10:0] w_py;
    logic [10:0] w_dx;
    logic [10:0] w_dy;
    logic [10:0] w_x_off;
    logic        w_inside;
    logic [14:0] w_addr;

    // 11-bit compare so a box hanging past column/row 1023 never wraps to 0
    assign w_x  = {1'b0, drawX};
    assign w_y  = {1'b0, drawY};
    assign w_px = {1'b0, pos_x};
    assign w_py = {1'b0, pos_y};

    assign w_inside = (w_x >= w_px) && (w_x <= w_px + W_M1) &&
                      (w_y >= w_py) && (w_y <= w_py + H_M1);

    assign w_dx    = w_x - w_px;
    assign w_dy    = w_y - w_py;
    assign w_x_off = mirror ? (W_M1 - w_dx) : w_dx;

    assign w_addr = 15'(32'(r_frame) * FRAME_SZ + (32'(w_dy) << XSH) + 32'(w_x_off));

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr <= '0;
            r_on   <= 1'b0;
        end else if (w_inside) begin
            r_addr <= w_addr;
            r_on   <= 1'b1;
        end else begin
            r_addr <= '0;
            r_on   <= 1'b0;
        end
    end

    // Animation only moves on frame_start so a frame never changes mid-screen
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_frame <= '0;
        end else if (frame_start) begin
            case (r_state)
                S_IDLE: begin
                    r_tick  <= '0;
                    r_frame <= '0;
                    if (walk_en) r_state <= S_WALK;
                end
                S_WALK: begin
                    if (!walk_en) begin
                        r_state <= S_IDLE;
                        r_tick  <= '0;
                        r_frame <= '0;
                    end else if (r_tick == TICK_LAST) begin
                        r_tick  <= '0;
                        r_frame <= (r_frame == FRAME_LAST) ? '0 : r_frame + 3'd1;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tick  <= '0;
                    r_frame <= '0;
                end
            endcase
        end
    end

    assign rom_address = r_addr;
    assign sprite_on   = r_on;
    assign frame_idx   = r_frame;

endmodule

// File: tb/tb_mai_forward_addr_gen.sv
// Scoreboard bench for mai_forward_addr_gen: a pulse-counting reference model predicts
// every registered output; directed checks cover the documented corner cases.
module tb_mai_forward_addr_gen;

    localparam int SPR_W = 64;
    localparam int SPR_H = 96;
    localparam int NF    = 5;
    localparam int TPF   = 6;

    logic        vga_clk;
    logic        reset_n;
    logic [9:0]  drawX, drawY, pos_x, pos_y;
    logic        frame_start, walk_en, mirror;
    logic [14:0] rom_address;
    logic        sprite_on;
    logic [2:0]  frame_idx;

    mai_forward_addr_gen #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NF), .TICKS_PER_FRAME(TPF)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .drawX(drawX), .drawY(drawY),
        .frame_start(frame_start), .walk_en(walk_en), .mirror(mirror),
        .pos_x(pos_x), .pos_y(pos_y), .rom_address(rom_address),
        .sprite_on(sprite_on), .frame_idx(frame_idx)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int addr;
        int on;
        int frame;
    } exp_t;

    exp_t sb[$];

    // Reference: in walk mode the frame is (pulses since entry / TPF) mod NF
    bit m_walk = 0;
    int m_n    = 0;

    function automatic int m_frame();
        return m_walk ? (m_n / TPF) % NF : 0;
    endfunction

    always @(negedge reset_n) begin
        m_walk = 0;
        m_n    = 0;
    end

    always @(posedge vga_clk) begin
        exp_t e;
        int x, y, px, py, xo;
        if (!reset_n) begin
            e.addr = 0; e.on = 0; e.frame = 0;
        end else begin
            x = drawX; y = drawY; px = pos_x; py = pos_y;
            if (x >= px && x < px + SPR_W && y >= py && y < py + SPR_H) begin
                xo     = mirror ? (SPR_W - 1) - (x - px) : (x - px);
                e.addr = (m_frame() * SPR_W * SPR_H + (y - py) * SPR_W + xo) % 32768;
                e.on   = 1;
            end else begin
                e.addr = 0; e.on = 0;
            end
            if (frame_start) begin
                if (!m_walk) begin
                    if (walk_en) begin m_walk = 1; m_n = 0; end
                end else if (!walk_en) begin
                    m_walk = 0; m_n = 0;
                end else begin
                    m_n++;
                end
            end
            e.frame = m_frame();
        end
        sb.push_back(e);
    end

    always @(posedge vga_clk) begin
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("sb_rom_address", int'(rom_address), e.addr);
            chk("sb_sprite_on", int'(sprite_on), e.on);
            chk("sb_frame_idx", int'(frame_idx), e.frame);
        end
    end

    task automatic pulse();
        @(negedge vga_clk) frame_start = 1'b1;
        @(negedge vga_clk) frame_start = 1'b0;
    endtask

    task automatic pix(input int x, input int y, input bit m, input int ea, input int eo, input string name);
        @(negedge vga_clk);
        drawX = 10'(x); drawY = 10'(y); mirror = m;
        @(posedge vga_clk);
        #2;
        chk({name, "_addr"}, int'(rom_address), ea);
        chk({name, "_on"}, int'(sprite_on), eo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; drawX = '0; drawY = '0; pos_x = '0; pos_y = '0;
        frame_start = 1'b0; walk_en = 1'b0; mirror = 1'b0;
        repeat (3) @(negedge vga_clk);
        chk("reset_addr", int'(rom_address), 0);
        chk("reset_on", int'(sprite_on), 0);
        chk("reset_frame", int'(frame_idx), 0);

        reset_n = 1'b1; pos_x = 10'd100; pos_y = 10'd200;
        pix(110, 205, 0, 330, 1, "t1_px");
        chk("t1_frame", int'(frame_idx), 0);
        pix(110, 205, 1, 373, 1, "t2_mirror");
        pix(99, 205, 1, 0, 0, "t2_left_out");
        pix(163, 205, 1, 320, 1, "t2_right_edge");
        pix(110, 205, 0, 330, 1, "t2_back");

        walk_en = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            pulse();
            chk("t3_frame", int'(frame_idx), (i < 7) ? 0 : (i < 13) ? 1 : 2);
        end
        pix(110, 205, 0, 12618, 1, "t3_px");

        walk_en = 1'b0;
        pulse();
        chk("t4_idle_frame", int'(frame_idx), 0);
        walk_en = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            pulse();
            chk("t4_frame", int'(frame_idx), ((i - 1) / 6) % 5);
        end
        walk_en = 1'b0;
        pulse();
        chk("t4_drop_frame", int'(frame_idx), 0);
        pulse();
        chk("t4_idle_hold", int'(frame_idx), 0);

        walk_en = 1'b1;
        repeat (25) pulse();
        chk("t5_frame", int'(frame_idx), 4);
        pix(163, 295, 0, 30719, 1, "t5_corner");
        pix(163, 296, 0, 0, 0, "t5_below");

        walk_en = 1'b0;
        pulse();
        walk_en = 1'b1;
        repeat (19) pulse();
        chk("t6_frame3", int'(frame_idx), 3);
        pix(110, 205, 0, 3 * 6144 + 330, 1, "t6_px");
        @(negedge vga_clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_addr", int'(rom_address), 0);
        chk("t6_async_on", int'(sprite_on), 0);
        chk("t6_async_frame", int'(frame_idx), 0);
        @(negedge vga_clk);
        walk_en = 1'b0;
        reset_n = 1'b1;
        repeat (3) pulse();
        chk("t6_post_idle", int'(frame_idx), 0);
        walk_en = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            pulse();
            chk("t6_restart", int'(frame_idx), (i < 7) ? 0 : 1);
        end

        for (int c = 0; c < 800; c++) begin
            @(negedge vga_clk);
            if ($urandom_range(0, 63) == 0) begin
                pos_x = 10'($urandom_range(0, 1023));
                pos_y = 10'($urandom_range(0, 1023));
            end
            drawX       = 10'(int'(pos_x) + $urandom_range(0, 79) - 8);
            drawY       = 10'(int'(pos_y) + $urandom_range(0, 111) - 8);
            mirror      = 1'($urandom_range(0, 1));
            walk_en     = ($urandom_range(0, 9) != 0);
            frame_start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
            else reset_n = 1'b1;
        end
        @(negedge vga_clk);
        frame_start = 1'b0;
        reset_n = 1'b1;
        repeat (3) @(negedge vga_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
